// File: rtl/pc_fetch_unit_pkg.sv
// Shared RISC-V fetch constants: reset PC, NOP encoding, redirect priority.
// Also carries the fetch FSM state type used by pc_fetch_unit.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Encoding order matches redirect priority, highest first.
    typedef enum logic [1:0] {
        REDIR_TRAP   = 2'd0,
        REDIR_MRET   = 2'd1,
        REDIR_BRANCH = 2'd2,
        REDIR_NONE   = 2'd3
    } redirect_sel_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: trap > mret > branch > sequential > hold.
// A misaligned redirect target is reported as a fault and the PC holds.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0]   pc,
    input  logic          run,
    input  logic          trap_taken,
    input  logic [31:0]   trap_vector,
    input  logic          mret,
    input  logic [31:0]   epc,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          stall,
    input  logic          imem_ready,
    output logic [31:0]   next_pc,
    output redirect_sel_e sel,
    output logic          flush,
    output logic          fault
);

    logic [31:0] target;
    logic        advance;

    always_comb begin
        sel    = REDIR_NONE;
        target = pc;
        priority case (1'b1)
            trap_taken: begin
                sel    = REDIR_TRAP;
                target = trap_vector;
            end
            mret: begin
                sel    = REDIR_MRET;
                target = epc;
            end
            branch_taken: begin
                sel    = REDIR_BRANCH;
                target = branch_target;
            end
            default: begin
                sel    = REDIR_NONE;
                target = pc;
            end
        endcase
    end

    assign flush   = sel != REDIR_NONE;
    assign fault   = flush && is_misaligned(target);
    assign advance = !flush && run && imem_ready && !stall;

    always_comb begin
        next_pc = pc;
        if (flush && !fault) begin
            next_pc = target;
        end else if (advance) begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN FSM and fetch/decode pipeline register.
// Redirect selection lives in pc_next_sel; flush/fault are same-cycle pulses.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        stall_in,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_id_out,
    output logic [31:0] instr_id_out,
    output logic        instr_valid_out,
    output logic        flush_out,
    output logic        misaligned_fault_out
);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   pc;
    logic [31:0]   next_pc;
    redirect_sel_e sel;
    logic          flush;
    logic          fault;
    logic          run;

    assign run = state == ST_RUN;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .run           (run),
        .trap_taken    (trap_taken_in),
        .trap_vector   (trap_vector_in),
        .mret          (mret_in),
        .epc           (epc_in),
        .branch_taken  (branch_taken_in),
        .branch_target (branch_target_in),
        .stall         (stall_in),
        .imem_ready    (imem_ready_in),
        .next_pc       (next_pc),
        .sel           (sel),
        .flush         (flush),
        .fault         (fault)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        imem_req_out = 1'b0;
        unique case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                state_next   = ST_RUN;
                imem_req_out = 1'b1;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Any flush, including a faulting one, discards the returned word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_id_out       <= 32'h0;
            instr_id_out    <= NOP_INSTR;
            instr_valid_out <= 1'b0;
        end else if (flush) begin
            instr_valid_out <= 1'b0;
        end else if (stall_in) begin
            instr_valid_out <= instr_valid_out;
        end else if (run && imem_ready_in) begin
            pc_id_out       <= pc;
            instr_id_out    <= imem_data_in;
            instr_valid_out <= 1'b1;
        end else begin
            instr_valid_out <= 1'b0;
        end
    end

    assign imem_addr_out        = pc;
    assign flush_out            = flush && !rst_in;
    assign misaligned_fault_out = fault && !rst_in;

    logic unused_sel;
    assign unused_sel = ^sel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit: one vector per clock cycle,
// inputs driven after the rising edge, outputs checked on the falling edge.
module tb_pc_fetch_unit;

    localparam logic        T   = 1'b1;
    localparam logic        F   = 1'b0;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] Z   = 32'h0;
    localparam int          NV  = 30;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] btgt;
        logic        trap;
        logic [31:0] tvec;
        logic        mret;
        logic [31:0] epc;
        logic        stall;
        logic        ready;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pid;
        logic [31:0] ins;
        logic        v;
        logic        fl;
        logic        ft;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] btgt;
    logic        trap;
    logic [31:0] tvec;
    logic        mret;
    logic [31:0] epc;
    logic        stall;
    logic        ready;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pid;
    logic [31:0] ins;
    logic        valid;
    logic        flush;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv [NV];

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .branch_taken_in      (br),
        .branch_target_in     (btgt),
        .trap_taken_in        (trap),
        .trap_vector_in       (tvec),
        .mret_in              (mret),
        .epc_in               (epc),
        .stall_in             (stall),
        .imem_ready_in        (ready),
        .imem_data_in         (data),
        .imem_req_out         (req),
        .imem_addr_out        (addr),
        .pc_id_out            (pid),
        .instr_id_out         (ins),
        .instr_valid_out      (valid),
        .flush_out            (flush),
        .misaligned_fault_out (fault)
    );

    function automatic vec_t mk(
        input logic r, input logic b, input logic [31:0] bt,
        input logic t, input logic [31:0] tv_, input logic m,
        input logic [31:0] e, input logic s, input logic rd,
        input logic [31:0] d, input logic q, input logic [31:0] a,
        input logic [31:0] p, input logic [31:0] i, input logic vv,
        input logic f, input logic ff);
        vec_t x;
        x.rst = r;   x.br = b;    x.btgt = bt;
        x.trap = t;  x.tvec = tv_; x.mret = m;
        x.epc = e;   x.stall = s; x.ready = rd;
        x.data = d;  x.req = q;   x.addr = a;
        x.pid = p;   x.ins = i;   x.v = vv;
        x.fl = f;    x.ft = ff;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst = x.rst;     br = x.br;       btgt = x.btgt;
        trap = x.trap;   tvec = x.tvec;   mret = x.mret;
        epc = x.epc;     stall = x.stall; ready = x.ready;
        data = x.data;
    endtask

    task automatic cmp(input int idx, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h want %h", idx, nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t x);
        drive(x);
        @(negedge clk);
        cmp(idx, "imem_req", {31'h0, req}, {31'h0, x.req});
        cmp(idx, "imem_addr", addr, x.addr);
        cmp(idx, "pc_id", pid, x.pid);
        cmp(idx, "instr_id", ins, x.ins);
        cmp(idx, "valid", {31'h0, valid}, {31'h0, x.v});
        cmp(idx, "flush", {31'h0, flush}, {31'h0, x.fl});
        cmp(idx, "fault", {31'h0, fault}, {31'h0, x.ft});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held with a competing branch; reset wins
        tv[0]  = mk(T,T,32'h40,F,Z,F,Z,F,T,Z, F,Z,Z,NOP,F,F,F);
        // BOOT cycle, then sequential fetch
        tv[1]  = mk(F,F,Z,F,Z,F,Z,F,T,32'h1111_0000, F,Z,Z,NOP,F,F,F);
        tv[2]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0000, T,Z,Z,NOP,F,F,F);
        tv[3]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0004,
                    T,32'h4,Z,32'hAAAA_0000,T,F,F);
        tv[4]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0008,
                    T,32'h8,32'h4,32'hAAAA_0004,T,F,F);
        // no data returned: valid drops, PC holds
        tv[5]  = mk(F,F,Z,F,Z,F,Z,F,F,Z,
                    T,32'hC,32'h8,32'hAAAA_0008,T,F,F);
        tv[6]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_000C,
                    T,32'hC,32'h8,32'hAAAA_0008,F,F,F);
        // branch at PC=0x10 to 0x40, returned word discarded
        tv[7]  = mk(F,T,32'h40,F,Z,F,Z,F,T,32'hDEAD_BEEF,
                    T,32'h10,32'hC,32'hAAAA_000C,T,T,F);
        tv[8]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0040,
                    T,32'h40,32'hC,32'hAAAA_000C,F,F,F);
        tv[9]  = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0044,
                    T,32'h44,32'h40,32'hAAAA_0040,T,F,F);
        // steer to 0x1C so the stall starts at PC=0x20 with a valid entry
        tv[10] = mk(F,T,32'h1C,F,Z,F,Z,F,T,32'hDEAD_BEEF,
                    T,32'h48,32'h44,32'hAAAA_0044,T,T,F);
        tv[11] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_001C,
                    T,32'h1C,32'h44,32'hAAAA_0044,F,F,F);
        tv[12] = mk(F,F,Z,F,Z,F,Z,T,T,32'hBBBB_0000,
                    T,32'h20,32'h1C,32'hAAAA_001C,T,F,F);
        tv[13] = mk(F,F,Z,F,Z,F,Z,T,T,32'hBBBB_0001,
                    T,32'h20,32'h1C,32'hAAAA_001C,T,F,F);
        tv[14] = mk(F,F,Z,F,Z,F,Z,T,T,32'hBBBB_0002,
                    T,32'h20,32'h1C,32'hAAAA_001C,T,F,F);
        // branch during stall applies immediately
        tv[15] = mk(F,T,32'h80,F,Z,F,Z,T,T,32'hBBBB_0003,
                    T,32'h20,32'h1C,32'hAAAA_001C,T,T,F);
        tv[16] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0080,
                    T,32'h80,32'h1C,32'hAAAA_001C,F,F,F);
        // trap and branch together: trap wins
        tv[17] = mk(F,T,32'h40,T,32'h100,F,Z,F,T,32'hDEAD_BEEF,
                    T,32'h84,32'h80,32'hAAAA_0080,T,T,F);
        tv[18] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0100,
                    T,32'h100,32'h80,32'hAAAA_0080,F,F,F);
        // misaligned branch target: fault, PC holds
        tv[19] = mk(F,T,32'h42,F,Z,F,Z,F,T,32'hDEAD_BEEF,
                    T,32'h104,32'h100,32'hAAAA_0100,T,T,T);
        tv[20] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0104,
                    T,32'h104,32'h100,32'hAAAA_0100,F,F,F);
        // mret beats branch
        tv[21] = mk(F,T,32'h40,F,Z,T,32'h200,F,T,32'hDEAD_BEEF,
                    T,32'h108,32'h104,32'hAAAA_0104,T,T,F);
        tv[22] = mk(F,F,Z,F,Z,T,32'hFFFF_FFFC,F,F,Z,
                    T,32'h200,32'h104,32'hAAAA_0104,F,T,F);
        // wrap from 0xFFFF_FFFC to 0
        tv[23] = mk(F,F,Z,F,Z,F,Z,F,T,32'hCCCC_FFFC,
                    T,32'hFFFF_FFFC,32'h104,32'hAAAA_0104,F,F,F);
        tv[24] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0000,
                    T,Z,32'hFFFF_FFFC,32'hCCCC_FFFC,T,F,F);
        tv[25] = mk(F,F,Z,F,Z,F,Z,T,T,32'hBBBB_0004,
                    T,32'h4,Z,32'hAAAA_0000,T,F,F);
        // reset mid-stall with a trap pending: no flush, reset wins
        tv[26] = mk(T,F,Z,T,32'h100,F,Z,T,T,32'hBBBB_0005,
                    T,32'h4,Z,32'hAAAA_0000,T,F,F);
        tv[27] = mk(F,F,Z,F,Z,F,Z,T,T,32'hBBBB_0006,
                    F,Z,Z,NOP,F,F,F);
        tv[28] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0000,
                    T,Z,Z,NOP,F,F,F);
        tv[29] = mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0004,
                    T,32'h4,Z,32'hAAAA_0000,T,F,F);

        drive(mk(T,F,Z,F,Z,F,Z,F,F,Z, F,Z,Z,NOP,F,F,F));
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(i, tv[i]);
        end

        // misaligned trap vector: one-cycle fault, then quiet, PC held at 8
        run_vec(100, mk(F,F,Z,T,32'h103,F,Z,F,T,32'hDEAD_BEEF,
                        T,32'h8,32'h4,32'hAAAA_0004,T,T,T));
        run_vec(101, mk(F,F,Z,F,Z,F,Z,F,F,Z,
                        T,32'h8,32'h4,32'hAAAA_0004,F,F,F));
        run_vec(102, mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_0008,
                        T,32'h8,32'h4,32'hAAAA_0004,F,F,F));
        run_vec(103, mk(F,F,Z,F,Z,F,Z,F,T,32'hAAAA_000C,
                        T,32'hC,32'h8,32'hAAAA_0008,T,F,F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
